icache: RTL
===========

Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's instruction port (imemREN/imemaddr → ihit/imemload) and the memory controller's instruction port (iREN/iaddr ← iwait/iload).
- The datapath holds PC and stalls fetch until ihit=1. The cache returns hits combinationally.
- On a miss, it runs a one-word fill from memory and then replays the access as a hit.
- Hit and miss performance counters are exposed for the system bench.

Parameters:
SETS, 16, number of one-word frames; power of two ≥2; IDX_W = log2(SETS)
TAG_W, 32-2-IDX_W (26 at default), tag width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
imemREN  in  1  datapath instruction read request
imemaddr  in  32  datapath instruction byte address
ihit  out  1  requested word valid this cycle
imemload  out  32  instruction word; 0 when ihit=0
iREN  out  1  memory instruction read request
iaddr  out  32  memory word address, bits[1:0]=00
iwait  in  1  memory busy; fill data valid on iload when iREN=1 and iwait=0
iload  in  32  memory read data
hit_count  out  32  count of cycles with ihit=1, wraps
miss_count  out  32  count of misses issued, wraps

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset state: all valid bits 0, tags and data 0, state IDLE, iREN=0, iaddr=0, ihit=0, imemload=0, both counters 0.
- Address split: [1:0] byte offset (ignored), [IDX_W+1:2] index, [31:IDX_W+2] tag.
- Frame: {valid, tag, data}. Stored in flops, no SRAM macro.
- State IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==addr tag).
  - ihit=hit and imemload=data[idx] in the same cycle (zero latency).
  - When imemREN=1 and hit=0: latch miss address {imemaddr[31:2],2'b00}, miss_count++, next state FETCH.
  - ihit stays 0 during that cycle.
- State FETCH:
  - iREN=1, iaddr=latched address; ihit=0 throughout.
  - When iwait=0: write frame[latched idx] = {1, latched tag, iload}, then return to IDLE.
  - The datapath's re-presented address hits in the first IDLE cycle.
- Miss latency: cycles with iwait=1, plus the fill cycle, plus the hit cycle. With 1-cycle memory (iwait=0 on the first FETCH cycle), total is 2 cycles from miss detect to ihit.
- imemaddr changes or imemREN drops during FETCH: the fill still completes using the latched address. The memory handshake is never aborted. There is no ihit unless the new address hits in IDLE.
- imemREN=0 in IDLE: ihit=0, no state change, no counting.
- No bypass of iload to imemload during the fill cycle.
- hit_count increments every cycle ihit=1, including repeated hits while the pipeline stalls. Both counters wrap 0xFFFFFFFF→0.
- Reset mid-FETCH: IDLE and iREN=0 immediately (asynchronous), all frames invalidated, and the in-flight fill is discarded.
- There is no write path and no invalidate port; self-modifying code is unsupported.

Decomposition:
- cpu_types_pkg gets:
  - ITAG_W and IIDX_W constants.
  - icachef_t: packed struct {tag, idx, bytoff} overlaying word_t.
  - icache_frame_t: packed struct {valid, tag, data}.
  - icache_state_t: enum {IDLE, FETCH}.
- No sub-module; the frame array, FSM and counters live in icache.
- Module-level wiring to the datapath-cache and cache-control interfaces is done by the parent memory subsystem.

Test Plan:
- Cold miss: imemREN=1, imemaddr=0x00000040; memory holds iwait=1 for 3 cycles, then iwait=0 with iload=0x8C010004 → iREN=1 with iaddr=0x40 for 4 cycles, ihit=0 throughout. Next cycle ihit=1, imemload=0x8C010004, miss_count=1, hit_count=1.
- Byte offset and repeated hits: after the fill above, imemaddr=0x00000043 held 5 cycles → ihit=1 every cycle, data 0x8C010004, iREN=0, hit_count increases by 5.
- Conflict eviction: fill 0x40 (idx0, tag1), then 0x80 (idx0, tag2) with iload=0x24020007 → 0x80 hits with 0x24020007. Re-access 0x40 misses again; miss_count=3.
- 1-cycle memory: miss at 0x4, iwait=0 on the first FETCH cycle → exactly 1 cycle of iREN=1, ihit=1 on the following cycle.
- Request drop mid-miss: miss at 0x100, drop imemREN during FETCH → fill completes and iREN falls after iwait=0. A later access to 0x100 hits immediately with no new miss.
- Reset mid-FETCH: assert RST while iREN=1 → iREN=0 before the next CLK edge. After release, a previously filled address misses, and both counters read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word type, instruction-cache address overlay,
// frame layout and cache controller states.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int IIDX_W = 4;
  localparam int ITAG_W = WORD_W - 2 - IIDX_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits, one-word
// miss fill from the memory controller, and hit/miss performance counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  frame_t        frame_r [SETS];
  icache_state_t state_r;
  icache_state_t state_next_s;
  logic [31:0]   miss_addr_r;
  logic [31:0]   hit_count_r;
  logic [31:0]   miss_count_r;

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;
  logic             hit_s;
  logic             miss_s;
  logic             fill_s;
  logic [31:0]      load_s;
  logic             unused_s;

  assign idx_s      = imemaddr[IDX_W+1:2];
  assign tag_s      = imemaddr[31:IDX_W+2];
  assign fill_idx_s = miss_addr_r[IDX_W+1:2];
  assign fill_tag_s = miss_addr_r[31:IDX_W+2];
  // Byte offset is irrelevant for word fetches.
  assign unused_s   = ^imemaddr[1:0];

  // Lookup: hits are only reported while idle so a fill never bypasses to the datapath.
  always_comb begin
    hit_s  = 1'b0;
    load_s = 32'h0000_0000;
    if ((state_r == IDLE) && imemREN && frame_r[idx_s].valid &&
        (frame_r[idx_s].tag == tag_s)) begin
      hit_s  = 1'b1;
      load_s = frame_r[idx_s].data;
    end else begin
      hit_s  = 1'b0;
      load_s = 32'h0000_0000;
    end
  end

  assign miss_s = (state_r == IDLE) && imemREN && !hit_s;
  assign fill_s = (state_r == FETCH) && !iwait;

  // Next-state logic for the fill controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_s) state_next_s = FETCH;
        else        state_next_s = IDLE;
      end
      FETCH: begin
        if (!iwait) state_next_s = IDLE;
        else        state_next_s = FETCH;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, miss address latch and performance counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= IDLE;
      miss_addr_r  <= 32'h0000_0000;
      hit_count_r  <= 32'h0000_0000;
      miss_count_r <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      if (miss_s) begin
        miss_addr_r  <= {imemaddr[31:2], 2'b00};
        miss_count_r <= miss_count_r + 32'd1;
      end
      if (hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
    end
  end

  // Frame array: reset invalidates everything, a completed fill writes one frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) begin
        frame_r[i] <= {($bits(frame_t)){1'b0}};
      end
    end else if (fill_s) begin
      frame_r[fill_idx_s] <= {1'b1, fill_tag_s, iload};
    end
  end

  assign ihit       = hit_s;
  assign imemload   = load_s;
  assign iREN       = (state_r == FETCH);
  assign iaddr      = miss_addr_r;
  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

endmodule
